serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that drives the single-bit full adder stage one bit per clock. It latches two N-bit operands and a carry-in, then presents one bit pair per cycle to the full adder (fa_a, fa_b, fa_cin). It consumes the full adder's sum and carry outputs (fa_s, fa_cout), recirculates the carry, and assembles the N-bit sum. It sits between the operand source and the one-bit full adder.

Parameters:
N, 8, operand/sum width in bits (N >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request to begin an addition; sampled only in IDLE
a_in  input  N  operand A, captured when start is accepted
b_in  input  N  operand B, captured when start is accepted
cin_in  input  1  initial carry-in, captured when start is accepted
fa_a  output  1  bit of A presented to the full adder
fa_b  output  1  bit of B presented to the full adder
fa_cin  output  1  current carry presented to the full adder
fa_s  input  1  sum bit returned by the full adder (combinational)
fa_cout  input  1  carry-out returned by the full adder (combinational)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result valid
sum_out  output  N  registered N-bit sum, held until the next completion
cout_out  output  1  registered final carry-out, held with sum_out

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n.
- Reset (rst_n=0 at an edge): state=IDLE. Count, A/B/sum shift registers, carry reg, sum_out, cout_out, done and busy all go to 0. Reset mid-RUN aborts the addition with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. fa_a/fa_b/fa_cin=0. On start=1 at an edge:
  - A_sh<=a_in, B_sh<=b_in, carry<=cin_in, count<=0
  - state transitions to RUN.
- RUN:
  - fa_a=A_sh[0], fa_b=B_sh[0], fa_cin=carry. These are combinational from registers.
  - At each edge: A_sh and B_sh shift right by one. sum_sh<={fa_s, sum_sh[N-1:1]}. carry<=fa_cout. count<=count+1.
  - When count==N-1 at an edge:
    - sum_out<={fa_s, sum_sh[N-1:1]}
    - cout_out<=fa_cout
    - state transitions to DONE.
- DONE: done=1 for exactly one cycle, busy=1. The next edge returns to IDLE unconditionally.
- Latency: start is accepted at edge E0. Bits are processed at E1..EN. done is high during the cycle following EN, i.e. N cycles after E0. A new start is accepted no earlier than the edge after DONE (throughput one op per N+2 cycles).
- start in RUN or DONE is ignored; it is not queued. Operand inputs are ignored outside start acceptance.
- sum_out/cout_out change only on the final RUN edge or on reset. They are stable during IDLE and during the next operation.
- Arithmetic: {cout_out,sum_out} = a_in + b_in + cin_in, computed modulo 2^(N+1). Bit 0 is processed first.
- The count register is ceil(log2(N))+1 bits wide; no wrap-around occurs within an operation.
- N=1: a single RUN cycle, then DONE.
- Full-adder outputs are assumed combinational from fa_a/fa_b/fa_cin. No registered path exists in the full-adder stage.

Test Plan:
- N=8, a_in=8'hA5, b_in=8'h3C, cin_in=0, start 1 cycle -> done pulse exactly 8 cycles after acceptance; sum_out=8'hE1, cout_out=0.
- a_in=8'hFF, b_in=8'h01, cin_in=0 -> sum_out=8'h00, cout_out=1. Carry ripples through all 8 serial cycles; fa_cin=1 from the 2nd bit onward.
- a_in=8'hFF, b_in=8'hFF, cin_in=1 -> sum_out=8'hFF, cout_out=1. busy high for 9 cycles, done high for 1 cycle.
- start pulsed again mid-RUN with different operands -> ignored; first result is unchanged; exactly one done pulse.
- rst_n=0 for one edge at RUN bit 4 -> next cycle IDLE with busy=0, sum_out=0, cout_out=0, and no done pulse. A fresh start with 8'h01+8'h01 then yields 8'h02.
- Back-to-back: start held high continuously with 8'h10+8'h20 -> a done pulse every 10 cycles, sum_out=8'h30 each time.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: latches two N-bit operands and a carry-in,
// feeds one bit pair per clock to an external one-bit full adder, recirculates
// the carry and assembles the N-bit sum (LSB first).
module serial_adder_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin_in,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_cin,
  input  logic         fa_s,
  input  logic         fa_cout,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum_out,
  output logic         cout_out
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   sum_sh;
  logic [N-1:0]   sum_next;
  logic           carry;
  logic [CW-1:0]  count;

  // New sum bit enters at the MSB; after N shifts bit 0 lands at position 0.
  // Written as a shifted concatenation so that N=1 elaborates cleanly.
  always_comb begin
    sum_next = N'({fa_s, sum_sh} >> 1);
  end

  // Full-adder operands are driven only while running, straight from registers.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state == StRun) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_cin = carry;
    end
  end

  // Controller FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            count <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_cout;
          count  <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            sum_out  <= sum_next;
            cout_out <= fa_cout;
            done     <= 1'b1;
            state    <= StDone;
          end
        end
        StDone: begin
          // start is not looked at here; it is only accepted back in idle.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with a behavioural one-bit full adder.
module tb_serial_adder_ctrl;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         cin_in;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_s;
  logic         fa_cout;
  logic         busy;
  logic         done;
  logic [N-1:0] sum_out;
  logic         cout_out;

  int tests;
  int fails;

  // Results of the last run_op call.
  int           lat;
  int           busy_cnt;
  int           done_cnt;
  logic [N-1:0] cin_vec;
  logic [N-1:0] a_vec;
  logic [N-1:0] res_sum;
  logic         res_cout;

  serial_adder_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_s     (fa_s),
    .fa_cout  (fa_cout),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; optionally pulse start again mid-run with other operands.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input bit mid_start);
    a_in   = a;
    b_in   = b;
    cin_in = c;
    start  = 1'b1;
    step();
    start    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    done_cnt = 0;
    cin_vec  = '0;
    a_vec    = '0;
    res_sum  = '0;
    res_cout = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k < N) begin
        cin_vec[k] = fa_cin;
        a_vec[k]   = fa_a;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat      = k;
          res_sum  = sum_out;
          res_cout = cout_out;
        end
      end
      if (mid_start && k == 3) begin
        a_in   = 8'hFF;
        b_in   = 8'hFF;
        cin_in = 1'b1;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    int seen;
    int t_done [3];
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout_out), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    rst_n = 1'b1;
    step();

    // A5 + 3C: carries into bits 3..6.
    run_op(8'hA5, 8'h3C, 1'b0, 1'b0);
    check("a5_lat", 32'(lat), 32'd8);
    check("a5_sum", 32'(res_sum), 32'hE1);
    check("a5_cout", 32'(res_cout), 32'd0);
    check("a5_fa_a", 32'(a_vec), 32'hA5);
    check("a5_fa_cin", 32'(cin_vec), 32'h78);
    check("a5_done_cnt", 32'(done_cnt), 32'd1);
    check("a5_hold", 32'(sum_out), 32'hE1);

    // FF + 01: carry ripples through every bit.
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    check("ff01_sum", 32'(res_sum), 32'h00);
    check("ff01_cout", 32'(res_cout), 32'd1);
    check("ff01_fa_cin", 32'(cin_vec), 32'hFE);

    // FF + FF + 1.
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    check("ffff_sum", 32'(res_sum), 32'hFF);
    check("ffff_cout", 32'(res_cout), 32'd1);
    check("ffff_busy_cnt", 32'(busy_cnt), 32'd9);
    check("ffff_done_cnt", 32'(done_cnt), 32'd1);
    check("ffff_lat", 32'(lat), 32'd8);

    // Mid-run start must be ignored.
    run_op(8'h12, 8'h34, 1'b0, 1'b1);
    check("mid_sum", 32'(res_sum), 32'h46);
    check("mid_cout", 32'(res_cout), 32'd0);
    check("mid_done_cnt", 32'(done_cnt), 32'd1);
    check("mid_hold", 32'(sum_out), 32'h46);

    // Reset during bit 4 aborts without a done pulse.
    a_in   = 8'h55;
    b_in   = 8'h0F;
    cin_in = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum_out), 32'd0);
    check("abort_cout", 32'(cout_out), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) seen++;
      step();
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0);
    check("post_rst_sum", 32'(res_sum), 32'h02);
    check("post_rst_cout", 32'(res_cout), 32'd0);

    // start held high: one op every N+2 cycles.
    a_in   = 8'h10;
    b_in   = 8'h20;
    cin_in = 1'b0;
    start  = 1'b1;
    seen   = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) begin
        if (seen < 3) t_done[seen] = k;
        seen++;
        check("b2b_sum", 32'(sum_out), 32'h30);
        check("b2b_cout", 32'(cout_out), 32'd0);
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(seen >= 3), 32'd1);
    if (seen >= 3) begin
      check("b2b_gap1", 32'(t_done[1] - t_done[0]), 32'd10);
      check("b2b_gap2", 32'(t_done[2] - t_done[1]), 32'd10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
